mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 153 +++++++++++++++
 tb/tb_mul_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-requester front end for a pipelined multiplier. It arbitrates with alternating
// priority and returns each in-order product to its issuer through a tag FIFO.
module mul_arbiter #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [DW-1:0]           req0_a,
    input  logic [DW-1:0]           req0_b,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [DW-1:0]           req1_a,
    input  logic [DW-1:0]           req1_b,
    output logic [DW-1:0]           mul_a,
    output logic [DW-1:0]           mul_b,
    output logic                    mul_val,
    input  logic                    mul_rdy,
    input  logic                    mul_commit,
    input  logic [2*DW-1:0]         mul_p,
    output logic                    resp0_val,
    output logic                    resp1_val,
    output logic [2*DW-1:0]         resp_p,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    err_orphan
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    req_id_e          prio_q, prio_d;
    req_id_e          tag_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             resp0_q, resp0_d;
    logic             resp1_q, resp1_d;
    logic [2*DW-1:0]  resp_p_q, resp_p_d;
    logic             err_q, err_d;

    logic             issue_en;
    logic             grant0;
    logic             grant1;
    logic             push;
    logic             pop;
    logic             orphan;
    req_id_e          push_id;

    // Grants are suppressed while reset is held so no operand leaks to the multiplier.
    always_comb begin
        issue_en = reset && mul_rdy && (cnt_q != FULL);
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (issue_en) begin
            if (req0_val && req1_val) begin
                grant0 = (prio_q == REQ0);
                grant1 = (prio_q == REQ1);
            end else begin
                grant0 = req0_val;
                grant1 = req1_val;
            end
        end
    end

    assign push    = grant0 | grant1;
    assign push_id = grant1 ? REQ1 : REQ0;
    assign pop     = mul_commit && (cnt_q != '0);
    assign orphan  = mul_commit && (cnt_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q   <= REQ0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            resp0_q  <= 1'b0;
            resp1_q  <= 1'b0;
            resp_p_q <= '0;
            err_q    <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            resp0_q  <= resp0_d;
            resp1_q  <= resp1_d;
            resp_p_q <= resp_p_d;
            err_q    <= err_d;
        end
    end

    // Tag storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr_q] <= push_id;
        end
    end

    always_comb begin
        prio_d   = prio_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        resp0_d  = 1'b0;
        resp1_d  = 1'b0;
        resp_p_d = resp_p_q;
        err_d    = err_q | orphan;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            prio_d   = grant0 ? REQ1 : REQ0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            resp_p_d = mul_p;
            resp0_d  = (tag_q[rd_ptr_q] == REQ0);
            resp1_d  = (tag_q[rd_ptr_q] == REQ1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        req0_rdy = grant0;
        req1_rdy = grant1;
        mul_val  = push;
        mul_a    = '0;
        mul_b    = '0;
        if (grant0) begin
            mul_a = req0_a;
            mul_b = req0_b;
        end else if (grant1) begin
            mul_a = req1_a;
            mul_b = req1_b;
        end
    end

    assign resp0_val   = resp0_q;
    assign resp1_val   = resp1_q;
    assign resp_p      = resp_p_q;
    assign outstanding = cnt_q;
    assign err_orphan  = err_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: acts as the multiplier and checks every output each cycle
// against a queue-based model of arbitration, tag order and orphan handling.
module tb_mul_arbiter;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int PW    = 2 * DW;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   req0_val, req1_val;
    logic                   req0_rdy, req1_rdy;
    logic [DW-1:0]          req0_a, req0_b, req1_a, req1_b;
    logic [DW-1:0]          mul_a, mul_b;
    logic                   mul_val, mul_rdy, mul_commit;
    logic [PW-1:0]          mul_p;
    logic                   resp0_val, resp1_val;
    logic [PW-1:0]          resp_p;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   err_orphan;

    mul_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_val   (req0_val),
        .req0_rdy   (req0_rdy),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_val   (req1_val),
        .req1_rdy   (req1_rdy),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_val    (mul_val),
        .mul_rdy    (mul_rdy),
        .mul_commit (mul_commit),
        .mul_p      (mul_p),
        .resp0_val  (resp0_val),
        .resp1_val  (resp1_val),
        .resp_p     (resp_p),
        .outstanding(outstanding),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state: outstanding requester IDs in issue order, per-requester result queues.
    int            m_prio;
    int            m_tags[$];
    bit            m_r0, m_r1, m_err;
    logic [PW-1:0] m_p;
    logic [PW-1:0] pipe[$];
    logic [PW-1:0] exp0[$], exp1[$];

    bit            obs_rdy0, obs_rdy1, obs_r0, obs_r1, obs_err;
    logic [PW-1:0] obs_p;
    logic [3:0]    obs_outst;

    task automatic run_cycle(input bit v0, input bit v1,
                             input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                             input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                             input bit mrdy, input bit commit, output int win);
        logic [DW-1:0] wa, wb;
        logic [PW-1:0] head;
        int            t;
        req0_val   = v0;
        req1_val   = v1;
        req0_a     = a0;
        req0_b     = b0;
        req1_a     = a1;
        req1_b     = b1;
        mul_rdy    = mrdy;
        mul_commit = commit;
        mul_p      = (pipe.size() > 0) ? pipe[0] : PW'($urandom);
        #1;
        win = -1;
        if (mrdy && m_tags.size() < DEPTH) begin
            if (v0 && v1)  win = m_prio;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        wa = (win == 0) ? a0 : (win == 1) ? a1 : '0;
        wb = (win == 0) ? b0 : (win == 1) ? b1 : '0;

        obs_rdy0  = req0_rdy;
        obs_rdy1  = req1_rdy;
        obs_r0    = resp0_val;
        obs_r1    = resp1_val;
        obs_err   = err_orphan;
        obs_p     = resp_p;
        obs_outst = 4'(outstanding);

        check_eq("req0_rdy", req0_rdy, win == 0);
        check_eq("req1_rdy", req1_rdy, win == 1);
        check_eq("mul_val", mul_val, win >= 0);
        check_eq("mul_a", mul_a, wa);
        check_eq("mul_b", mul_b, wb);
        check_eq("outstanding", outstanding, m_tags.size());
        check_eq("resp0_val", resp0_val, m_r0);
        check_eq("resp1_val", resp1_val, m_r1);
        check_eq("resp_p", resp_p, m_p);
        check_eq("err_orphan", err_orphan, m_err);
        if (m_r0 && exp0.size() > 0) check_eq("order0", resp_p, exp0.pop_front());
        if (m_r1 && exp1.size() > 0) check_eq("order1", resp_p, exp1.pop_front());

        m_r0 = 1'b0;
        m_r1 = 1'b0;
        if (commit) begin
            if (m_tags.size() > 0) begin
                t   = m_tags.pop_front();
                m_p = mul_p;
                if (t == 0) m_r0 = 1'b1;
                else        m_r1 = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            if (pipe.size() > 0) head = pipe.pop_front();
        end
        if (win >= 0) begin
            m_tags.push_back(win);
            m_prio = 1 - win;
            head   = PW'(wa) * PW'(wb);
            pipe.push_back(head);
            if (win == 0) exp0.push_back(head);
            else          exp1.push_back(head);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle with requests pending; outputs must clear before any edge.
    task automatic do_reset();
        req0_val   = 1'b1;
        req1_val   = 1'b1;
        mul_rdy    = 1'b1;
        mul_commit = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_resp0", resp0_val, 0);
        check_eq("rst_resp1", resp1_val, 0);
        check_eq("rst_resp_p", resp_p, 0);
        check_eq("rst_err", err_orphan, 0);
        check_eq("rst_rdy0", req0_rdy, 0);
        check_eq("rst_rdy1", req1_rdy, 0);
        check_eq("rst_mul_val", mul_val, 0);
        m_tags.delete();
        exp0.delete();
        exp1.delete();
        m_prio = 0;
        m_r0   = 1'b0;
        m_r1   = 1'b0;
        m_p    = '0;
        m_err  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        reset      = 1'b0;
        req0_val   = 1'b0;
        req1_val   = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        mul_rdy    = 1'b0;
        mul_commit = 1'b0;
        mul_p      = '0;
        do_reset();

        // Single requester, product returned four cycles after issue
        run_cycle(1, 0, 3, 5, 0, 0, 1, 0, w);
        check_eq("s1_rdy0", obs_rdy0, 1);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0, 0, 1, 0, w);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 1, w);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 0, w);
        check_eq("s1_resp0", obs_r0, 1);
        check_eq("s1_resp1", obs_r1, 0);
        check_eq("s1_resp_p", obs_p, 15);

        // Contention alternates grants and returns results in grant order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 1, 2, 2, 7, 7, 1, 0, w);
            check_eq("s2_grant1", obs_rdy1, i % 2);
        end
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 0, 0, 0, 0, 0, 1, i < 4, w);
            if (i > 0) begin
                check_eq("s2_resp_p", obs_p, ((i - 1) % 2 == 1) ? 49 : 4);
                check_eq("s2_resp0", obs_r0, (i - 1) % 2 == 0);
            end
        end

        // Full FIFO blocks issue even when a commit lands in the same cycle
        for (int i = 0; i < 4; i++) run_cycle(1, 0, 16'(i + 1), 3, 0, 0, 1, 0, w);
        run_cycle(1, 1, 9, 9, 8, 8, 1, 1, w);
        check_eq("s3_outstanding", obs_outst, 4);
        check_eq("s3_full_rdy0", obs_rdy0, 0);
        check_eq("s3_full_rdy1", obs_rdy1, 0);
        run_cycle(1, 0, 9, 9, 0, 0, 1, 0, w);
        check_eq("s3_rdy_back", obs_rdy0, 1);
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 0, 0, 0, 1, 1, w);

        // Simultaneous grant and commit at two outstanding
        run_cycle(0, 1, 0, 0, 11, 12, 1, 0, w);
        run_cycle(1, 0, 5, 6, 0, 0, 1, 0, w);
        run_cycle(1, 0, 13, 14, 0, 0, 1, 1, w);
        check_eq("s4_rdy0", obs_rdy0, 1);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 0, w);
        check_eq("s4_outstanding", obs_outst, 2);
        check_eq("s4_head_resp1", obs_r1, 1);
        check_eq("s4_head_resp0", obs_r0, 0);
        check_eq("s4_head_p", obs_p, 132);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0, 0, 1, i < 2, w);

        // Orphan commit right after reset sets the sticky flag without a response
        do_reset();
        run_cycle(0, 0, 0, 0, 0, 0, 1, 1, w);
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 0, 0, 0, 0, 0, 1, 0, w);
            check_eq("s5_err", obs_err, 1);
            check_eq("s5_no_resp", obs_r0 | obs_r1, 0);
            check_eq("s5_resp_p", obs_p, 0);
        end

        // Reset with three in flight: stale commits become orphans, priority restarts at 0
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 16'(i + 2), 16'(i + 3), 0, 0, 1, 0, w);
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0, 0, 1, 1, w);
        run_cycle(1, 1, 21, 2, 22, 3, 1, 0, w);
        check_eq("s6_err", obs_err, 1);
        check_eq("s6_prio0", obs_rdy0, 1);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 1, w);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 0, w);
        check_eq("s6_resp_p", obs_p, 42);

        // Randomized traffic, occasionally committing with nothing outstanding
        for (int i = 0; i < 1500; i++) begin
            bit c;
            c = (pipe.size() > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
            run_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 3) != 0, c, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
